result_mux_pipe: RTL and testbench
==================================

Name: result_mux_pipe

Overview:
- Parametrised N-source writeback result selector with a registered, elastic output stage.
- Picks one of NUM_SRC WIDTH-bit sources (ALU, load data, PC+4, immediate, ...) by Result_SRC.
- Carries the destination register tag with the result.
- Decouples writeback from upstream through a 2-entry skid buffer with valid/ready handshake; sits between execute/memory and the register-file write port.

Parameters:
- WIDTH, 32, data width of each source and of Result.
- NUM_SRC, 4, number of selectable sources; legal range 2..2**SEL_W.
- SEL_W, 2, width of Result_SRC.
- RD_W, 5, destination register tag width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Src_Data  input  NUM_SRC*WIDTH  flattened sources; source k at bits [k*WIDTH +: WIDTH].
- Result_SRC  input  SEL_W  source select.
- Rd_Addr  input  RD_W  destination register.
- Reg_Write  input  1  write-enable request.
- In_Valid  input  1  upstream beat valid.
- In_Ready  output  1  block can accept a beat.
- Result  output  WIDTH  selected data.
- Result_Rd  output  RD_W  destination tag.
- Result_Reg_Write  output  1  qualified write enable.
- Result_Sel_Err  output  1  beat carried an out-of-range select.
- Out_Valid  output  1  output beat valid.
- Out_Ready  input  1  downstream accepts.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously clears both entries and the state to EMPTY.
  - Reset values: Out_Valid=0, Result=0, Result_Rd=0, Result_Reg_Write=0, Result_Sel_Err=0, In_Ready=1 (after reset is released).
  - Reset mid-operation discards all held beats.
- Accept and release:
  - Accept when In_Valid && In_Ready.
  - Release when Out_Valid && Out_Ready.
- Select, computed at accept:
  - Result_SRC < NUM_SRC: data = Src_Data[Result_SRC*WIDTH +: WIDTH], sel_err = 0.
  - Result_SRC >= NUM_SRC: data = 0, sel_err = 1, write enable forced 0.
  - Rd_Addr == 0: write enable forced 0, data forced 0 (x0 hard-wired).
  - Otherwise write enable = Reg_Write.
- Storage:
  - Main entry drives the outputs; skid entry holds an overflow beat.
  - Captured beat = {data, Rd, we, sel_err}.
- States, encoded by occupancy:
  - EMPTY: Out_Valid=0, In_Ready=1. On accept, load main and go to ONE.
  - ONE: Out_Valid=1, In_Ready=1.
    - Accept only: load skid, go to FULL.
    - Release only: go to EMPTY.
    - Accept and release in the same cycle: load main with the new beat, stay ONE (throughput 1 beat/cycle).
  - FULL: Out_Valid=1, In_Ready=0.
    - On release, move skid to main and go to ONE.
    - No accept is possible.
- In_Ready is a register output (skid not occupied); it has no combinational path from Out_Ready.
- Latency: accept at edge N gives Out_Valid at edge N+1, with the macro undefined.
- Output stability: main entry holds stable while Out_Valid && !Out_Ready.
- Ordering: strict FIFO, and no beat is dropped or duplicated.

Optional Feature:
- Macro: RESULT_MUX_BYPASS_EN.
- Defined:
  - In EMPTY with In_Valid && Out_Ready, the qualified beat is presented combinationally on the outputs with Out_Valid=1 in the same cycle, and is not stored (0-cycle latency).
  - If Out_Ready=0, the normal path is used.
- Undefined: all outputs come purely from registers, with 1-cycle minimum latency.

Test Plan:
- Reset then single beat: Src_Data={4'hD..,0xCCCC0003,0xBBBB0002,0xAAAA0001}, Result_SRC=1, Rd=7, Reg_Write=1, Out_Ready=1 -> next cycle Out_Valid=1, Result=0xBBBB0002, Result_Rd=7, Result_Reg_Write=1.
- Backpressure: Out_Ready=0, push beats sel=0,1,2 -> In_Ready drops after 2 accepts; the third beat is held upstream. Raise Out_Ready -> outputs 0xAAAA0001, 0xBBBB0002, 0xCCCC0003 in order, no loss.
- Streaming: In_Valid=Out_Ready=1 for 8 cycles with incrementing sel -> 8 outputs on consecutive cycles, and In_Ready stays 1.
- Rd_Addr=0 with Reg_Write=1, sel=2 -> Result=0, Result_Reg_Write=0.
- NUM_SRC=3, Result_SRC=3 -> Result=0, Result_Sel_Err=1, Result_Reg_Write=0.
- Assert rst_n low while in FULL -> Out_Valid=0 immediately (asynchronous). After release: In_Ready=1, and no stale beat is emitted.
- With RESULT_MUX_BYPASS_EN defined, in EMPTY with Out_Ready=1 -> Out_Valid=1 and Result valid in the same cycle as In_Valid.

Source files
------------

// File: rtl/result_mux_pipe_if.sv
// Bus bundle for result_mux_pipe: upstream select/beat signals and downstream result handshake.
// master = environment (execute/memory side and register-file side), slave = result_mux_pipe.
interface result_mux_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int RD_W    = 5
);
    logic [NUM_SRC*WIDTH-1:0] Src_Data;
    logic [SEL_W-1:0]         Result_SRC;
    logic [RD_W-1:0]          Rd_Addr;
    logic                     Reg_Write;
    logic                     In_Valid;
    logic                     In_Ready;
    logic [WIDTH-1:0]         Result;
    logic [RD_W-1:0]          Result_Rd;
    logic                     Result_Reg_Write;
    logic                     Result_Sel_Err;
    logic                     Out_Valid;
    logic                     Out_Ready;

    modport master (
        output Src_Data, Result_SRC, Rd_Addr, Reg_Write, In_Valid, Out_Ready,
        input  In_Ready, Result, Result_Rd, Result_Reg_Write, Result_Sel_Err, Out_Valid
    );

    modport slave (
        input  Src_Data, Result_SRC, Rd_Addr, Reg_Write, In_Valid, Out_Ready,
        output In_Ready, Result, Result_Rd, Result_Reg_Write, Result_Sel_Err, Out_Valid
    );
endinterface

// File: rtl/result_mux_pipe.sv
// N-source writeback result selector with a 2-entry skid buffer on the output.
// Optional RESULT_MUX_BYPASS_EN: zero-latency pass-through when empty and downstream is ready.
module result_mux_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int RD_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    result_mux_pipe_if.slave    bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [RD_W-1:0]  rd;
        logic             we;
        logic             sel_err;
    } beat_t;

    localparam logic [SEL_W:0] NUM_SRC_CMP = (SEL_W+1)'(NUM_SRC);

    logic [WIDTH-1:0] src_arr [NUM_SRC];
    logic [WIDTH-1:0] sel_data;
    logic             sel_ok;
    logic             rd_zero;
    beat_t            in_beat;
    beat_t            out_beat;

    state_t state_reg, state_next;
    beat_t  main_reg, main_next;
    beat_t  skid_reg, skid_next;
    logic   in_ready_reg, in_ready_next;

    logic accept;
    logic release_beat;
    logic out_valid;
    logic bypass_fire;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_arr[gi] = bus.Src_Data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.Result_SRC == SEL_W'(k)) begin
                sel_data = src_arr[k];
            end
        end
    end

    // Out-of-range selects and writes to x0 both yield zero data and no write.
    assign sel_ok  = ({1'b0, bus.Result_SRC} < NUM_SRC_CMP);
    assign rd_zero = (bus.Rd_Addr == '0);

    always_comb begin
        in_beat.data    = (sel_ok && !rd_zero) ? sel_data : '0;
        in_beat.rd      = bus.Rd_Addr;
        in_beat.we      = sel_ok && !rd_zero && bus.Reg_Write;
        in_beat.sel_err = !sel_ok;
    end

`ifdef RESULT_MUX_BYPASS_EN
    assign bypass_fire = (state_reg == EMPTY) && bus.In_Valid && bus.Out_Ready;
`else
    assign bypass_fire = 1'b0;
`endif

    assign out_valid    = (state_reg != EMPTY) || bypass_fire;
    assign out_beat     = bypass_fire ? in_beat : main_reg;
    assign accept       = bus.In_Valid && in_ready_reg;
    assign release_beat = out_valid && bus.Out_Ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (accept && !bypass_fire) begin
                    main_next  = in_beat;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && release_beat) begin
                    main_next = in_beat;
                end else if (accept) begin
                    skid_next  = in_beat;
                    state_next = FULL;
                end else if (release_beat) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (release_beat) begin
                    main_next  = skid_reg;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        in_ready_next = (state_next != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            in_ready_reg <= in_ready_next;
        end
    end

    assign bus.In_Ready         = in_ready_reg;
    assign bus.Out_Valid        = out_valid;
    assign bus.Result           = out_beat.data;
    assign bus.Result_Rd        = out_beat.rd;
    assign bus.Result_Reg_Write = out_beat.we;
    assign bus.Result_Sel_Err   = out_beat.sel_err;

endmodule

// File: tb/tb_result_mux_pipe.sv
// Directed bench for result_mux_pipe: a 4-source instance plus a 3-source instance
// for out-of-range selects. Bypass-specific timing is used when RESULT_MUX_BYPASS_EN is set.
module tb_result_mux_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    result_mux_pipe_if #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2), .RD_W(5)) bus ();
    result_mux_pipe_if #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .RD_W(5)) bus3 ();

    result_mux_pipe #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2), .RD_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    result_mux_pipe #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .RD_W(5)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] rd, input logic we);
        bus.In_Valid   = v;
        bus.Result_SRC = sel;
        bus.Rd_Addr    = rd;
        bus.Reg_Write  = we;
    endtask

    task automatic check_out(input string tag, input logic [31:0] data, input logic [4:0] rd,
                             input logic we, input logic err);
        check_val({tag, ".valid"}, 64'(bus.Out_Valid), 64'd1);
        check_val({tag, ".data"}, 64'(bus.Result), 64'(data));
        check_val({tag, ".rd"}, 64'(bus.Result_Rd), 64'(rd));
        check_val({tag, ".we"}, 64'(bus.Result_Reg_Write), 64'(we));
        check_val({tag, ".err"}, 64'(bus.Result_Sel_Err), 64'(err));
    endtask

    logic [31:0] src_vals [4];

    initial begin
        checks = 0;
        errors = 0;
        src_vals[0] = 32'hAAAA0001;
        src_vals[1] = 32'hBBBB0002;
        src_vals[2] = 32'hCCCC0003;
        src_vals[3] = 32'hDDDD0004;

        rst_n          = 1'b0;
        bus.Src_Data   = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        bus.Out_Ready  = 1'b0;
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        bus3.Src_Data   = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        bus3.Out_Ready  = 1'b0;
        bus3.In_Valid   = 1'b0;
        bus3.Result_SRC = 2'd0;
        bus3.Rd_Addr    = 5'd0;
        bus3.Reg_Write  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst.valid", 64'(bus.Out_Valid), 64'd0);
        check_val("rst.data", 64'(bus.Result), 64'd0);
        check_val("rst.rd", 64'(bus.Result_Rd), 64'd0);
        check_val("rst.we", 64'(bus.Result_Reg_Write), 64'd0);
        check_val("rst.err", 64'(bus.Result_Sel_Err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst.in_ready", 64'(bus.In_Ready), 64'd1);

        // Single beat
        bus.Out_Ready = 1'b1;
        drive(1'b1, 2'd1, 5'd7, 1'b1);
`ifdef RESULT_MUX_BYPASS_EN
        #1;
        check_out("single", 32'hBBBB0002, 5'd7, 1'b1, 1'b0);
`endif
        @(posedge clk);
        #1 bus.In_Valid = 1'b0;
        @(negedge clk);
`ifndef RESULT_MUX_BYPASS_EN
        check_out("single", 32'hBBBB0002, 5'd7, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
`endif
        check_val("single.drain", 64'(bus.Out_Valid), 64'd0);

        // Backpressure: two accepts fill the buffer, third beat is held upstream
        bus.Out_Ready = 1'b0;
        drive(1'b1, 2'd0, 5'd1, 1'b1);
        @(posedge clk); @(negedge clk);
        check_val("bp.in_ready1", 64'(bus.In_Ready), 64'd1);
        check_out("bp.first", 32'hAAAA0001, 5'd1, 1'b1, 1'b0);
        drive(1'b1, 2'd1, 5'd2, 1'b1);
        @(posedge clk); @(negedge clk);
        check_val("bp.in_ready_full", 64'(bus.In_Ready), 64'd0);
        drive(1'b1, 2'd2, 5'd3, 1'b1);
        @(posedge clk); @(negedge clk);
        check_val("bp.in_ready_hold", 64'(bus.In_Ready), 64'd0);
        check_out("bp.stable", 32'hAAAA0001, 5'd1, 1'b1, 1'b0);
        bus.Out_Ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_out("bp.second", 32'hBBBB0002, 5'd2, 1'b1, 1'b0);
        check_val("bp.in_ready_again", 64'(bus.In_Ready), 64'd1);
        @(posedge clk); @(negedge clk);
        check_out("bp.third", 32'hCCCC0003, 5'd3, 1'b1, 1'b0);
        bus.In_Valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("bp.drain", 64'(bus.Out_Valid), 64'd0);

        // Streaming: one beat per cycle, In_Ready never drops
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i % 4), 5'(8 + i), 1'b1);
`ifdef RESULT_MUX_BYPASS_EN
            #1;
            check_out($sformatf("stream%0d", i), src_vals[i % 4], 5'(8 + i), 1'b1, 1'b0);
`endif
            @(posedge clk); @(negedge clk);
`ifndef RESULT_MUX_BYPASS_EN
            check_out($sformatf("stream%0d", i), src_vals[i % 4], 5'(8 + i), 1'b1, 1'b0);
`endif
            check_val($sformatf("stream%0d.in_ready", i), 64'(bus.In_Ready), 64'd1);
        end
        bus.In_Valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("stream.drain", 64'(bus.Out_Valid), 64'd0);

        // Write to x0 is suppressed and data forced to zero
        bus.Out_Ready = 1'b0;
        drive(1'b1, 2'd2, 5'd0, 1'b1);
        @(posedge clk); @(negedge clk);
        check_out("x0", 32'h0, 5'd0, 1'b0, 1'b0);
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("x0.drain", 64'(bus.Out_Valid), 64'd0);

        // Out-of-range select on the 3-source instance
        bus3.In_Valid   = 1'b1;
        bus3.Result_SRC = 2'd3;
        bus3.Rd_Addr    = 5'd5;
        bus3.Reg_Write  = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("selerr.valid", 64'(bus3.Out_Valid), 64'd1);
        check_val("selerr.data", 64'(bus3.Result), 64'd0);
        check_val("selerr.err", 64'(bus3.Result_Sel_Err), 64'd1);
        check_val("selerr.we", 64'(bus3.Result_Reg_Write), 64'd0);
        check_val("selerr.rd", 64'(bus3.Result_Rd), 64'd5);
        bus3.Out_Ready  = 1'b1;
        bus3.Result_SRC = 2'd2;
        bus3.Rd_Addr    = 5'd4;
        @(posedge clk); @(negedge clk);
        check_val("sel3_2.data", 64'(bus3.Result), 64'hCCCC0003);
        check_val("sel3_2.err", 64'(bus3.Result_Sel_Err), 64'd0);
        check_val("sel3_2.we", 64'(bus3.Result_Reg_Write), 64'd1);
        bus3.In_Valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("sel3.drain", 64'(bus3.Out_Valid), 64'd0);

`ifdef RESULT_MUX_BYPASS_EN
        // Zero-latency pass-through from EMPTY
        bus.Out_Ready = 1'b1;
        drive(1'b1, 2'd3, 5'd9, 1'b1);
        #1;
        check_out("bypass", 32'hDDDD0004, 5'd9, 1'b1, 1'b0);
        @(posedge clk);
        #1 bus.In_Valid = 1'b0;
        @(negedge clk);
        check_val("bypass.drain", 64'(bus.Out_Valid), 64'd0);
`endif

        // Asynchronous reset while FULL discards held beats
        bus.Out_Ready = 1'b0;
        drive(1'b1, 2'd0, 5'd1, 1'b1);
        @(posedge clk); @(negedge clk);
        drive(1'b1, 2'd1, 5'd2, 1'b1);
        @(posedge clk); @(negedge clk);
        check_val("full.in_ready", 64'(bus.In_Ready), 64'd0);
        bus.In_Valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("arst.valid", 64'(bus.Out_Valid), 64'd0);
        check_val("arst.data", 64'(bus.Result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.Out_Ready = 1'b1;
        @(negedge clk);
        check_val("arst.in_ready", 64'(bus.In_Ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val($sformatf("arst.nostale%0d", i), 64'(bus.Out_Valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
